// File: rtl/bsg_vanilla_pkg.sv
// Shared vanilla-core types used by the fetch buffer.
// Holds the instruction word type and the canonical NOP encoding.
package bsg_vanilla_pkg;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] op;
  } instruction_s;

  // addi x0, x0, 0
  localparam instruction_s vanilla_nop_instr_gp = 32'h0000_0013;

endpackage

// File: rtl/dual_issue_fetch_buffer_if.sv
// Fetch-side and issue-side handshake bundle of the dual-issue fetch buffer.
// The buffer takes the slave modport; the fetch stage / decoder side takes master.
interface dual_issue_fetch_buffer_if #(
  parameter int depth_p    = 4,
  parameter int pc_width_p = 32
) ();
  import bsg_vanilla_pkg::*;

  localparam int cnt_w = $clog2(depth_p + 1);

  logic                  fetch_v_i;
  instruction_s          fetch_instr_i;
  logic [pc_width_p-1:0] fetch_pc_i;
  logic                  fetch_ready_o;

  logic [1:0]            issue_v_o;
  instruction_s          issue_instr_o [0:1];
  logic [pc_width_p-1:0] issue_pc_o    [0:1];
  logic                  single_issue_i;
  logic                  issue_yumi_i;
  logic                  flush_i;
  logic [cnt_w-1:0]      count_o;

  modport slave (
    input  fetch_v_i, fetch_instr_i, fetch_pc_i, single_issue_i, issue_yumi_i, flush_i,
    output fetch_ready_o, issue_v_o, issue_instr_o, issue_pc_o, count_o
  );

  modport master (
    output fetch_v_i, fetch_instr_i, fetch_pc_i, single_issue_i, issue_yumi_i, flush_i,
    input  fetch_ready_o, issue_v_o, issue_instr_o, issue_pc_o, count_o
  );

endinterface

// File: rtl/dual_issue_fetch_mem.sv
// Entry storage for the fetch buffer: one write port, two asynchronous read ports.
// Contents are deliberately not reset; validity is tracked by the owner's count.
module dual_issue_fetch_mem #(
  parameter int width_p  = 64,
  parameter int els_p    = 4,
  parameter int addr_w_p = $clog2(els_p)
) (
  input  logic                          clk_i,
  input  logic                          w_v,
  input  logic [addr_w_p-1:0]           w_addr,
  input  logic [width_p-1:0]            w_data,
  input  logic [1:0][addr_w_p-1:0]      r_addr,
  output logic [1:0][width_p-1:0]       r_data
);

  logic [width_p-1:0] mem_reg [els_p];

  always_ff @(posedge clk_i) begin
    if (w_v) begin
      mem_reg[w_addr] <= w_data;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    assign r_data[gi] = mem_reg[r_addr[gi]];
  end

endmodule

// File: rtl/dual_issue_fetch_buffer.sv
// Circular instruction queue presenting the two oldest entries as an ordered issue pair.
// Define VANILLA_DUAL_ISSUE_EN for pair issue; otherwise it acts as a single-issue FIFO.
module dual_issue_fetch_buffer
  import bsg_vanilla_pkg::*;
#(
  parameter int depth_p    = 4,
  parameter int pc_width_p = 32
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  dual_issue_fetch_buffer_if.slave  bus
);

  localparam int ptr_w = $clog2(depth_p);
  localparam int cnt_w = $clog2(depth_p + 1);
  localparam logic [cnt_w-1:0] full_count = cnt_w'(depth_p);

  typedef struct packed {
    instruction_s          instr;
    logic [pc_width_p-1:0] pc;
  } entry_s;

  localparam int entry_w = $bits(entry_s);

  logic [ptr_w-1:0]              wptr_reg, rptr_reg;
  logic [cnt_w-1:0]              count_reg, count_next;
  logic                          push, pop_v, pop2;
  logic [1:0]                    pop_cnt;
  logic [1:0]                    slot_v;
  entry_s                        w_entry;
  logic [1:0][ptr_w-1:0]         r_addr;
  logic [1:0][entry_w-1:0]       r_data;

  // Ready depends only on registered occupancy, never on this cycle's yumi.
  assign bus.fetch_ready_o = (count_reg != full_count);
  assign push    = bus.fetch_v_i & bus.fetch_ready_o & ~bus.flush_i;
  assign slot_v[0] = (count_reg != '0);
  assign pop_v   = bus.issue_yumi_i & slot_v[0] & ~bus.flush_i;

`ifdef VANILLA_DUAL_ISSUE_EN
  assign slot_v[1] = (count_reg >= cnt_w'(2));
  assign pop2      = pop_v & slot_v[1] & ~bus.single_issue_i;
`else
  logic unused_single_issue;
  assign slot_v[1] = 1'b0;
  assign pop2      = 1'b0;
  assign unused_single_issue = bus.single_issue_i;
`endif

  assign pop_cnt    = pop2 ? 2'd2 : {1'b0, pop_v};
  assign count_next = count_reg + cnt_w'(push) - cnt_w'(pop_cnt);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else if (bus.flush_i) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) begin
        wptr_reg <= wptr_reg + ptr_w'(1);
      end
      rptr_reg  <= rptr_reg + ptr_w'(pop_cnt);
      count_reg <= count_next;
    end
  end

  assign w_entry.instr = bus.fetch_instr_i;
  assign w_entry.pc    = bus.fetch_pc_i;

  dual_issue_fetch_mem #(
    .width_p (entry_w),
    .els_p   (depth_p)
  ) mem (
    .clk_i  (clk_i),
    .w_v    (push),
    .w_addr (wptr_reg),
    .w_data (w_entry),
    .r_addr (r_addr),
    .r_data (r_data)
  );

  // Slot gi shows the entry gi places behind the head; empty slots show a NOP at PC 0.
  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    entry_s rd_entry;
    assign r_addr[gi] = rptr_reg + ptr_w'(gi);
    assign rd_entry   = r_data[gi];
    assign bus.issue_instr_o[gi] = slot_v[gi] ? rd_entry.instr : vanilla_nop_instr_gp;
    assign bus.issue_pc_o[gi]    = slot_v[gi] ? rd_entry.pc    : '0;
  end

  assign bus.issue_v_o = slot_v;
  assign bus.count_o   = count_reg;

  no_yumi_when_empty: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) bus.issue_yumi_i |-> bus.issue_v_o[0]
  );

endmodule

// File: tb/tb_dual_issue_fetch_buffer.sv
// Directed bench for dual_issue_fetch_buffer; expectations follow VANILLA_DUAL_ISSUE_EN.
// Each stimulus step prints one transaction line.
module tb_dual_issue_fetch_buffer;

  localparam bit DUAL =
`ifdef VANILLA_DUAL_ISSUE_EN
    1'b1;
`else
    1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  dual_issue_fetch_buffer_if #(.depth_p(4), .pc_width_p(32)) bus ();

  dual_issue_fetch_buffer #(.depth_p(4), .pc_width_p(32)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  function automatic logic [31:0] mk(input logic [31:0] pc);
    return {16'hBEEF, pc[15:0]};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag, input int cnt, input logic [1:0] v,
                             input logic [31:0] i0, input logic [31:0] pc0,
                             input logic [31:0] i1, input logic [31:0] pc1);
    check_eq({tag, ".count"}, 64'(bus.count_o), 64'(cnt));
    check_eq({tag, ".ready"}, 64'(bus.fetch_ready_o), 64'(cnt != 4));
    check_eq({tag, ".v"},     64'(bus.issue_v_o), 64'(v));
    check_eq({tag, ".i0"},    64'(bus.issue_instr_o[0]), 64'(i0));
    check_eq({tag, ".pc0"},   64'(bus.issue_pc_o[0]), 64'(pc0));
    check_eq({tag, ".i1"},    64'(bus.issue_instr_o[1]), 64'(i1));
    check_eq({tag, ".pc1"},   64'(bus.issue_pc_o[1]), 64'(pc1));
  endtask

  task automatic step(input logic fv, input logic [31:0] pc, input logic y,
                      input logic s, input logic f);
    bus.fetch_v_i      = fv;
    bus.fetch_instr_i  = mk(pc);
    bus.fetch_pc_i     = pc;
    bus.issue_yumi_i   = y;
    bus.single_issue_i = s;
    bus.flush_i        = f;
    @(posedge clk);
    #1;
    bus.fetch_v_i      = 1'b0;
    bus.issue_yumi_i   = 1'b0;
    bus.single_issue_i = 1'b0;
    bus.flush_i        = 1'b0;
    $display("txn push=%0b pc=%h yumi=%0b single=%0b flush=%0b -> count=%0d v=%b pc0=%h",
             fv, pc, y, s, f, bus.count_o, bus.issue_v_o, bus.issue_pc_o[0]);
  endtask

  initial begin
    bus.fetch_v_i      = 1'b0;
    bus.fetch_instr_i  = '0;
    bus.fetch_pc_i     = '0;
    bus.issue_yumi_i   = 1'b0;
    bus.single_issue_i = 1'b0;
    bus.flush_i        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 0, 2'b00, NOP, 0, NOP, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back pushes, then a pair pop at count 3
    step(1, 32'h100, 0, 0, 0);
    check_state("push_a", 1, 2'b01, mk(32'h100), 32'h100, NOP, 0);
    step(1, 32'h104, 0, 0, 0);
    check_state("push_b", 2, DUAL ? 2'b11 : 2'b01, mk(32'h100), 32'h100,
                DUAL ? mk(32'h104) : NOP, DUAL ? 32'h104 : 0);
    step(1, 32'h108, 0, 0, 0);
    check_state("push_c", 3, DUAL ? 2'b11 : 2'b01, mk(32'h100), 32'h100,
                DUAL ? mk(32'h104) : NOP, DUAL ? 32'h104 : 0);
    step(0, 0, 1, 0, 0);
    check_state("pop_pair", DUAL ? 1 : 2, 2'b01, DUAL ? mk(32'h108) : mk(32'h104),
                DUAL ? 32'h108 : 32'h104, NOP, 0);
    step(0, 0, 0, 0, 1);
    check_state("flush1", 0, 2'b00, NOP, 0, NOP, 0);

    // Single-issue verdict, then pair request with only one valid
    step(1, 32'h100, 0, 0, 0);
    step(1, 32'h104, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    check_state("pop_single", 1, 2'b01, mk(32'h104), 32'h104, NOP, 0);
    step(0, 0, 1, 0, 0);
    check_state("pop_last", 0, 2'b00, NOP, 0, NOP, 0);

    // Fill, drop a push while full, pop 2 while pushing at count 2
    step(1, 32'h200, 0, 0, 0);
    step(1, 32'h204, 0, 0, 0);
    step(1, 32'h208, 0, 0, 0);
    step(1, 32'h20C, 0, 0, 0);
    check_state("full", 4, DUAL ? 2'b11 : 2'b01, mk(32'h200), 32'h200,
                DUAL ? mk(32'h204) : NOP, DUAL ? 32'h204 : 0);
    step(1, 32'h210, 0, 0, 0);
    check_state("full_drop", 4, DUAL ? 2'b11 : 2'b01, mk(32'h200), 32'h200,
                DUAL ? mk(32'h204) : NOP, DUAL ? 32'h204 : 0);
    step(0, 0, 1, 1, 0);
    check_state("drain1", 3, DUAL ? 2'b11 : 2'b01, mk(32'h204), 32'h204,
                DUAL ? mk(32'h208) : NOP, DUAL ? 32'h208 : 0);
    step(0, 0, 1, 1, 0);
    check_state("drain2", 2, DUAL ? 2'b11 : 2'b01, mk(32'h208), 32'h208,
                DUAL ? mk(32'h20C) : NOP, DUAL ? 32'h20C : 0);
    step(1, 32'h300, 1, 0, 0);
    check_state("push_pop2", DUAL ? 1 : 2, 2'b01, DUAL ? mk(32'h300) : mk(32'h20C),
                DUAL ? 32'h300 : 32'h20C, NOP, 0);
    step(0, 0, 0, 0, 1);

    // Six pushes with alternating 1/2 pops across the pointer wrap
    step(1, 32'h400, 0, 0, 0);
    step(1, 32'h404, 0, 0, 0);
    step(1, 32'h408, 0, 0, 0);
    step(1, 32'h40C, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    check_state("wrap_a", 3, DUAL ? 2'b11 : 2'b01, mk(32'h404), 32'h404,
                DUAL ? mk(32'h408) : NOP, DUAL ? 32'h408 : 0);
    step(1, 32'h410, 1, 0, 0);
    check_state("wrap_b", DUAL ? 2 : 3, DUAL ? 2'b11 : 2'b01,
                DUAL ? mk(32'h40C) : mk(32'h408), DUAL ? 32'h40C : 32'h408,
                DUAL ? mk(32'h410) : NOP, DUAL ? 32'h410 : 0);
    step(1, 32'h414, 1, 1, 0);
    check_state("wrap_c", DUAL ? 2 : 3, DUAL ? 2'b11 : 2'b01,
                DUAL ? mk(32'h410) : mk(32'h40C), DUAL ? 32'h410 : 32'h40C,
                DUAL ? mk(32'h414) : NOP, DUAL ? 32'h414 : 0);
    step(0, 0, 1, 0, 0);
    check_state("wrap_d", DUAL ? 0 : 2, DUAL ? 2'b00 : 2'b01,
                DUAL ? NOP : mk(32'h410), DUAL ? 0 : 32'h410, NOP, 0);
    step(0, 0, 0, 0, 1);

    // Flush beats a simultaneous push and yumi at count 3
    step(1, 32'h600, 0, 0, 0);
    step(1, 32'h604, 0, 0, 0);
    step(1, 32'h608, 0, 0, 0);
    step(1, 32'h60C, 1, 0, 1);
    check_state("flush_prio", 0, 2'b00, NOP, 0, NOP, 0);
    step(1, 32'h500, 0, 0, 0);
    check_state("after_flush", 1, 2'b01, mk(32'h500), 32'h500, NOP, 0);

    // Asynchronous reset mid-stream, checked before any clock edge
    step(1, 32'h700, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check_state("async_rst", 0, 2'b00, NOP, 0, NOP, 0);
    @(negedge clk) rst_n = 1'b1;
    step(1, 32'h800, 0, 0, 0);
    check_state("post_rst", 1, 2'b01, mk(32'h800), 32'h800, NOP, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
